ram_stream_reader: RTL and testbench

- Upstream address-sequencer and stream adapter for the single-port synchronous RAM model (registered read, 1-cycle latency, addr/din/dout/we interface).
- Accepts a burst command (start address, length), issues sequential reads, and absorbs the RAM latency in a small skid FIFO.
- Presents the read words as a valid/ready stream toward the PE-array feeders.
- Read-only: RAM write port tied off.

---
 rtl/ram_stream_reader_pkg.sv | 20 ++
 rtl/ram_stream_reader_if.sv | 40 ++++
 rtl/ram_stream_reader_skid_fifo.sv | 62 ++++++
 rtl/ram_stream_reader.sv | 116 +++++++++++
 tb/tb_ram_stream_reader.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
// Holds the FSM encoding, FIFO counter sizing and the default address stride.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH_DEFAULT = 2;
    localparam int CNT_W              = $clog2(FIFO_DEPTH_DEFAULT + 1);
    localparam int DEFAULT_STRIDE     = 1;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, RAM-port and output-stream bundle of the RAM stream reader.
// master is the reader's view; slave is the view of the command source, RAM and consumer.
interface ram_stream_reader_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
`ifdef RAM_STREAM_READER_STRIDE_EN
    logic [AW-1:0] cmd_stride;
`endif
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          done;
    logic          busy;

    modport master (
`ifdef RAM_STREAM_READER_STRIDE_EN
        input  cmd_stride,
`endif
        input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
        output cmd_ready, ram_addr, ram_we, ram_din, out_valid, out_data, done, busy
    );

    modport slave (
`ifdef RAM_STREAM_READER_STRIDE_EN
        output cmd_stride,
`endif
        output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
        input  cmd_ready, ram_addr, ram_we, ram_din, out_valid, out_data, done, busy
    );

endinterface

// File: rtl/ram_stream_reader_skid_fifo.sv
// Skid FIFO absorbing the RAM read latency; head and valid come straight from registers.
// Latency: a push at edge N is visible at the head from edge N; push into a full FIFO is dropped unless popped the same cycle.
module ram_stream_skid_fifo
    import ram_stream_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 2,
    parameter int CW    = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          head_vld,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign head     = mem[rd_ptr];
    assign head_vld = (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst address sequencer turning RAM reads into a valid/ready stream (RAM_STREAM_READER_STRIDE_EN adds cmd_stride).
// Latency: first word valid 2 cycles after the command handshake; issue stalls when FIFO plus in-flight reads would overflow.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    ram_stream_reader_if.master bus
);
    localparam int CW = cnt_width(FIFO_DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] stride;
    logic [AW:0]   remaining;
    logic          rd_pending;
    logic          done_q;
    logic          issue;
    logic          pop;
    logic          drained;
    logic [CW-1:0] fifo_count;
    logic          fifo_vld;
    logic [DW-1:0] fifo_head;
    logic [CW:0]   occupancy;

    // Occupancy counts the read already in flight so that a word never arrives to a full FIFO.
    assign pop       = fifo_vld && bus.out_ready;
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(rd_pending) - (CW+1)'(pop);
    assign issue     = (state == RUN) && (remaining != '0) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign drained   = !rd_pending && (fifo_count == '0) && !pop;

    assign bus.ram_addr  = addr_q;
    assign bus.ram_we    = 1'b0;
    assign bus.ram_din   = '0;
    assign bus.out_valid = fifo_vld;
    assign bus.out_data  = fifo_head;
    assign bus.done      = done_q;
    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = (bus.cmd_len == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (issue && (remaining == (AW+1)'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            remaining  <= '0;
            rd_pending <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_pending <= issue;
            done_q     <= (state == DRAIN) && drained;
            if ((state == IDLE) && bus.cmd_valid) begin
                addr_q    <= bus.cmd_addr;
                remaining <= bus.cmd_len;
            end else if (issue) begin
                addr_q    <= addr_q + stride;
                remaining <= remaining - (AW+1)'(1);
            end
        end
    end

`ifdef RAM_STREAM_READER_STRIDE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stride <= AW'(DEFAULT_STRIDE);
        end else if ((state == IDLE) && bus.cmd_valid) begin
            stride <= bus.cmd_stride;
        end
    end
`else
    assign stride = AW'(DEFAULT_STRIDE);
`endif

    ram_stream_skid_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pending),
        .push_data (bus.ram_dout),
        .pop       (pop),
        .head      (fifo_head),
        .head_vld  (fifo_vld),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model preloaded with addr^A5A5, bursts checked against an expected-word queue.
module tb_ram_stream_reader;

    logic clk;
    logic reset;
    ram_stream_reader_if #(.AW(16), .DW(16)) bus ();

    ram_stream_reader #(.AW(16), .DW(16), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:65535];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

    int total = 0;
    int bad   = 0;

    logic [15:0] got [$];
    int first_v, done_cyc, done_cnt, nacc, first_acc, last_acc, adv, maxocc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // mode 0: always ready; 1: ready pattern 1,0,0 repeating; 2: random ready
    task automatic run_burst(input logic [15:0] a, input logic [16:0] len, input logic [15:0] stride,
                             input int mode, input int abort_after);
        logic [15:0] exp_q [$];
        logic [15:0] last_addr;
        logic [15:0] prev_data;
        logic        prev_stall;
        int          budget;
        got.delete();
        for (int k = 0; k < int'(len); k++) exp_q.push_back(word_at(a + 16'(k) * stride));
        first_v = -1; done_cyc = -1; done_cnt = 0; nacc = 0;
        first_acc = -1; last_acc = -1; adv = 0; maxocc = 0;
        prev_stall = 1'b0; prev_data = '0;
        budget = 40 + 4 * int'(len);

        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
`ifdef RAM_STREAM_READER_STRIDE_EN
        bus.cmd_stride = stride;
`endif
        chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("busy_after_cmd", {31'd0, bus.busy}, 1);
        chk("start_addr", {16'd0, bus.ram_addr}, {16'd0, a});
        last_addr = bus.ram_addr;

        for (int cyc = 0; cyc < budget; cyc++) begin
            if (abort_after > 0 && nacc >= abort_after) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((cyc % 3) == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (int'(dut.u_fifo.count) > maxocc) maxocc = int'(dut.u_fifo.count);
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("cmd_ready_at_done", {31'd0, bus.cmd_ready}, 1);
                    chk("valid_low_at_done", {31'd0, bus.out_valid}, 0);
                end
            end
            if (bus.out_valid && first_v < 0) first_v = cyc;
            if (prev_stall) begin
                chk("hold_valid", {31'd0, bus.out_valid}, 1);
                chk("hold_data", {16'd0, bus.out_data}, {16'd0, prev_data});
            end
            if (bus.ram_addr != last_addr) begin
                adv++;
                chk("addr_step", {16'd0, bus.ram_addr}, {16'd0, last_addr + stride});
                last_addr = bus.ram_addr;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (nacc < exp_q.size()) chk("word", {16'd0, bus.out_data}, {16'd0, exp_q[nacc]});
                else chk("extra_word", 1, 0);
                got.push_back(bus.out_data);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                nacc++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            @(posedge clk); #1;
        end

        if (abort_after == 0) begin
            if (done_cyc < 0) chk("done_timeout", 0, 1);
            chk("done_once", done_cnt, 1);
            chk("word_count", nacc, int'(len));
            chk("addr_advances", adv, (stride == 16'd0) ? 0 : int'(len));
            chk("fifo_max_ok", {31'd0, (maxocc <= 2)}, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b0;
`ifdef RAM_STREAM_READER_STRIDE_EN
        bus.cmd_stride = 16'd1;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_ram_addr", {16'd0, bus.ram_addr}, 0);
        chk("ram_we_zero", {31'd0, bus.ram_we}, 0);
        chk("ram_din_zero", {16'd0, bus.ram_din}, 0);

        // Basic burst with fixed expected words.
        run_burst(16'h0010, 17'd4, 16'd1, 0, 0);
        chk("first_valid_lat", first_v, 2);
        chk("consecutive", last_acc - first_acc, 3);
        if (got.size() == 4) begin
            chk("w0", {16'd0, got[0]}, 32'hA5B5);
            chk("w1", {16'd0, got[1]}, 32'hA5B4);
            chk("w2", {16'd0, got[2]}, 32'hA5B7);
            chk("w3", {16'd0, got[3]}, 32'hA5B6);
        end else begin
            chk("basic_size", got.size(), 4);
        end

        // Address wrap.
        run_burst(16'hFFFE, 17'd4, 16'd1, 0, 0);
        if (got.size() == 4) chk("wrap_w2", {16'd0, got[2]}, 32'hA5A5);

        // Backpressure.
        run_burst(16'h0100, 17'd8, 16'd1, 1, 0);

        // Zero-length command.
        run_burst(16'h0200, 17'd0, 16'd1, 0, 0);
        chk("len0_no_valid", first_v, -1);
        chk("len0_done_fast", {31'd0, (done_cyc >= 0 && done_cyc <= 2)}, 1);

        // Reset in the middle of a burst.
        run_burst(16'h0300, 17'd16, 16'd1, 0, 5);
        chk("abort_accepted", nacc, 5);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 0);
        chk("midrst_busy", {31'd0, bus.busy}, 0);
        chk("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
        chk("midrst_done", {31'd0, bus.done}, 0);
        reset = 1'b0;
        run_burst(16'h0020, 17'd2, 16'd1, 0, 0);

`ifdef RAM_STREAM_READER_STRIDE_EN
        run_burst(16'h0000, 17'd3, 16'd3, 0, 0);
        if (got.size() == 3) chk("stride_w2", {16'd0, got[2]}, {16'd0, word_at(16'h0006)});
        run_burst(16'h0040, 17'd4, 16'd0, 2, 0);
`endif

        // Randomized bursts.
        for (int t = 0; t < 12; t++) begin
            run_burst(16'($urandom), 17'($urandom_range(0, 24)), 16'd1, int'($urandom_range(0, 2)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
